// File: rtl/avr_ppgm_pkg.sv
// Shared definitions for the AVR high-voltage parallel programming sequencer:
// host op codes, FSM state encoding and a small op classifier.
package avr_ppgm_pkg;

    localparam logic [3:0] OP_CLR      = 4'd0;
    localparam logic [3:0] OP_LOAD_CMD = 4'd1;
    localparam logic [3:0] OP_ADDR_LO  = 4'd2;
    localparam logic [3:0] OP_ADDR_HI  = 4'd3;
    localparam logic [3:0] OP_DATA_LO  = 4'd4;
    localparam logic [3:0] OP_DATA_HI  = 4'd5;
    localparam logic [3:0] OP_PAGEL    = 4'd6;
    localparam logic [3:0] OP_PROG     = 4'd7;
    localparam logic [3:0] OP_READ     = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_BSY_GAP,
        S_WAIT_RDY,
        S_READ_WAIT,
        S_SAMPLE
    } state_e;

    // Ops that latch a byte into the DUT with an XTAL1 pulse.
    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LOAD_CMD) && (op <= OP_DATA_HI);
    endfunction

endpackage

// File: rtl/avr_ppgm_sync2.sv
// Two-flop synchronizer for the asynchronous RDY/BSY pin.
module avr_ppgm_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= 2'b00;
        else         sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/avr_ppgm_seq.sv
// Strobe sequencer: turns one-cycle host commands into timed XTAL1/PAGEL/WR/OE
// waveforms for AVR HV parallel programming, with RDY polling and timeout.
module avr_ppgm_seq
    import avr_ppgm_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int PULSE_CYC   = 4,
    parameter int TIMEOUT_CYC = 48000
) (
    input  logic       osc,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       timeout,
    input  logic       dut_rdy,
    input  logic [7:0] dut_q,
    output logic       dut_xtal,
    output logic       dut_pagel,
    output logic       dut_wr_n,
    output logic       dut_oe_n,
    output logic       dut_xa0,
    output logic       dut_xa1,
    output logic       dut_bs1,
    output logic       dut_bs2,
    output logic [7:0] dut_data,
    output logic       dut_data_oe
);

    // Counter holds "cycles remaining minus one" for the current state.
    localparam logic [15:0] SETUP_LD   = 16'(SETUP_CYC - 1);
    localparam logic [15:0] PULSE_LD   = 16'(PULSE_CYC - 1);
    localparam logic [15:0] TIMEOUT_LD = 16'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  xa_q, xa_d;
    logic        bs1_q, bs1_d, bs2_q, bs2_d;
    logic [7:0]  data_q, data_d, rd_data_q, rd_data_d;
    logic        timeout_q, timeout_d;
    logic        rdy_s, accept, cnt_done;

    avr_ppgm_sync2 u_rdy_sync (
        .clk_i  (osc),
        .rst_ni (rst_n),
        .d_i    (dut_rdy),
        .q_o    (rdy_s)
    );

    assign accept   = cmd_valid && (state_q == S_IDLE) && (cmd_op <= OP_READ);
    assign cnt_done = (cnt_q == 16'd0);

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_CLR;
            xa_q      <= '0;
            bs1_q     <= 1'b0;
            bs2_q     <= 1'b0;
            data_q    <= '0;
            rd_data_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            xa_q      <= xa_d;
            bs1_q     <= bs1_d;
            bs2_q     <= bs2_d;
            data_q    <= data_d;
            rd_data_q <= rd_data_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q - 16'd1;
        op_d      = op_q;
        xa_d      = xa_q;
        bs1_d     = bs1_q;
        bs2_d     = bs2_q;
        data_d    = data_q;
        rd_data_d = rd_data_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = cnt_q;
                if (accept) begin
                    op_d = cmd_op;
                    case (cmd_op)
                        OP_LOAD_CMD: begin xa_d = 2'b10; bs1_d = 1'b0; end
                        OP_ADDR_LO:  begin xa_d = 2'b00; bs1_d = 1'b0; end
                        OP_ADDR_HI:  begin xa_d = 2'b00; bs1_d = 1'b1; end
                        OP_DATA_LO:  begin xa_d = 2'b01; bs1_d = 1'b0; end
                        OP_DATA_HI:  begin xa_d = 2'b01; bs1_d = 1'b1; end
                        OP_PROG, OP_READ: begin
                            bs1_d = cmd_data[0];
                            bs2_d = cmd_data[1];
                        end
                        default: ;
                    endcase
                    if (is_load(cmd_op)) data_d = cmd_data;
                    // CLR borrows the one-cycle SAMPLE state as its busy cycle.
                    if (cmd_op == OP_CLR) begin
                        timeout_d = 1'b0;
                        state_d   = S_SAMPLE;
                    end else begin
                        state_d = S_SETUP;
                        cnt_d   = SETUP_LD;
                    end
                end
            end
            S_SETUP: if (cnt_done) begin
                state_d = (op_q == OP_READ) ? S_READ_WAIT : S_PULSE;
                cnt_d   = PULSE_LD;
            end
            S_PULSE: if (cnt_done) begin
                state_d = (op_q == OP_PROG) ? S_BSY_GAP : S_HOLD;
                cnt_d   = SETUP_LD;
            end
            S_HOLD: if (cnt_done) state_d = S_IDLE;
            S_BSY_GAP: if (cnt_done) begin
                state_d = S_WAIT_RDY;
                cnt_d   = TIMEOUT_LD;
            end
            S_WAIT_RDY: begin
                // RDY wins over expiry when both land in the same cycle.
                if (rdy_s) begin
                    state_d = S_IDLE;
                end else if (cnt_done) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end
            end
            S_READ_WAIT: if (cnt_done) begin
                state_d   = S_SAMPLE;
                rd_data_d = dut_q;
            end
            S_SAMPLE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = (state_q == S_IDLE);
        dut_xtal    = (state_q == S_PULSE) && is_load(op_q);
        dut_pagel   = (state_q == S_PULSE) && (op_q == OP_PAGEL);
        dut_wr_n    = !((state_q == S_PULSE) && (op_q == OP_PROG));
        dut_oe_n    = !((op_q == OP_READ) &&
                        ((state_q == S_SETUP) || (state_q == S_READ_WAIT)));
        dut_data_oe = is_load(op_q) &&
                      ((state_q == S_SETUP) || (state_q == S_PULSE) || (state_q == S_HOLD));
        rd_valid    = (state_q == S_SAMPLE) && (op_q == OP_READ);
    end

    assign rd_data  = rd_data_q;
    assign timeout  = timeout_q;
    assign dut_xa0  = xa_q[0];
    assign dut_xa1  = xa_q[1];
    assign dut_bs1  = bs1_q;
    assign dut_bs2  = bs2_q;
    assign dut_data = data_q;

endmodule

// File: tb/tb_avr_ppgm_seq.sv
// Scoreboard bench for avr_ppgm_seq: stimulus pushes expected strobe events,
// a negedge monitor measures every strobe / rd_valid pulse and pops to compare.
module tb_avr_ppgm_seq;
    import avr_ppgm_pkg::*;

    localparam int TO = 50;

    logic       osc = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [3:0] cmd_op = '0;
    logic [7:0] cmd_data = '0;
    logic       cmd_ready, rd_valid, timeout;
    logic [7:0] rd_data;
    logic       dut_rdy = 1'b1;
    logic [7:0] dut_q = '0;
    logic       dut_xtal, dut_pagel, dut_wr_n, dut_oe_n;
    logic       dut_xa0, dut_xa1, dut_bs1, dut_bs2;
    logic [7:0] dut_data;
    logic       dut_data_oe;

    avr_ppgm_seq #(.SETUP_CYC(2), .PULSE_CYC(4), .TIMEOUT_CYC(TO)) dut (
        .osc(osc), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_ready(cmd_ready), .rd_data(rd_data),
        .rd_valid(rd_valid), .timeout(timeout), .dut_rdy(dut_rdy), .dut_q(dut_q),
        .dut_xtal(dut_xtal), .dut_pagel(dut_pagel), .dut_wr_n(dut_wr_n),
        .dut_oe_n(dut_oe_n), .dut_xa0(dut_xa0), .dut_xa1(dut_xa1),
        .dut_bs1(dut_bs1), .dut_bs2(dut_bs2), .dut_data(dut_data),
        .dut_data_oe(dut_data_oe)
    );

    always #5 osc = ~osc;

    int cyc = 0;
    always @(posedge osc) cyc <= cyc + 1;

    // Event kinds: 0 XTAL, 1 PAGEL, 2 WR, 3 OE, 4 rd_valid
    typedef struct {
        int         kind;
        int         acc;
        int         off;
        int         width;
        logic       chk_data;
        logic [7:0] data;
        logic [1:0] xa;
        logic       bs1;
        logic       bs2;
        logic       doe;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int acc, input int off, input int width,
                        input logic chk_data, input logic [7:0] data, input logic [1:0] xa,
                        input logic bs1, input logic bs2, input logic doe);
        exp_t e;
        e.kind = kind; e.acc = acc; e.off = off; e.width = width;
        e.chk_data = chk_data; e.data = data; e.xa = xa;
        e.bs1 = bs1; e.bs2 = bs2; e.doe = doe;
        sb.push_back(e);
    endtask

    // Monitor: cycle numbering is "acceptance edge k -> first busy cycle k+1".
    initial begin
        logic [4:0] prev, cur;
        int         st[5];
        logic [7:0] cd[5];
        logic [1:0] cxa[5];
        logic       cb1[5], cb2[5], cdoe[5];
        exp_t       e;
        prev = '0;
        forever begin
            @(negedge osc);
            cur = {rd_valid, ~dut_oe_n, ~dut_wr_n, dut_pagel, dut_xtal};
            for (int k = 0; k < 5; k++) begin
                if (cur[k] && !prev[k]) begin
                    st[k]   = cyc + 1;
                    cd[k]   = (k == 4) ? rd_data : dut_data;
                    cxa[k]  = {dut_xa1, dut_xa0};
                    cb1[k]  = dut_bs1;
                    cb2[k]  = dut_bs2;
                    cdoe[k] = dut_data_oe;
                end else if (cur[k] && dut_data_oe) begin
                    cdoe[k] = 1'b1;
                end
                if (mon_en && !cur[k] && prev[k]) begin
                    if (sb.size() == 0) begin
                        chk($sformatf("unexpected_evt%0d", k), 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("evt_kind", k, e.kind);
                        chk($sformatf("evt%0d_start", k), st[k] - e.acc, e.off);
                        chk($sformatf("evt%0d_width", k), cyc + 1 - st[k], e.width);
                        chk($sformatf("evt%0d_xa", k), int'(cxa[k]), int'(e.xa));
                        chk($sformatf("evt%0d_bs1", k), int'(cb1[k]), int'(e.bs1));
                        chk($sformatf("evt%0d_bs2", k), int'(cb2[k]), int'(e.bs2));
                        chk($sformatf("evt%0d_data_oe", k), int'(cdoe[k]), int'(e.doe));
                        if (e.chk_data) chk($sformatf("evt%0d_data", k), int'(cd[k]), int'(e.data));
                    end
                end
            end
            prev = cur;
        end
    end

    task automatic issue(input logic [3:0] op, input logic [7:0] d, output int k);
        @(posedge osc); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        @(posedge osc); #1;
        k = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int k, output int lat);
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge osc);
            if (cmd_ready) begin
                lat = cyc + 1 - k;
                break;
            end
        end
    endtask

    // Directed vectors: op, operand, DUT q, expected XA/BS1/BS2/dut_data after op
    localparam int NV = 7;
    logic [3:0] v_op  [NV] = '{OP_LOAD_CMD, OP_ADDR_LO, OP_ADDR_HI, OP_DATA_LO, OP_DATA_HI, OP_PAGEL, OP_READ};
    logic [7:0] v_d   [NV] = '{8'h40, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h01};
    logic [7:0] v_q   [NV] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5};
    logic [1:0] v_xa  [NV] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
    logic       v_bs1 [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] v_dd  [NV] = '{8'h40, 8'h12, 8'h34, 8'h56, 8'h78, 8'h78, 8'h00};

    initial begin
        int k, lat, m;
        bit seen;
        // Reset state
        repeat (2) @(posedge osc);
        #1;
        chk("rst_xtal", int'(dut_xtal), 0);
        chk("rst_wr_n", int'(dut_wr_n), 1);
        chk("rst_oe_n", int'(dut_oe_n), 1);
        chk("rst_data_oe", int'(dut_data_oe), 0);
        chk("rst_xa_bs", int'({dut_xa1, dut_xa0, dut_bs1, dut_bs2}), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_timeout", int'(timeout), 0);
        @(negedge osc); rst_n = 1'b1;
        @(negedge osc);
        chk("rst_ready", int'(cmd_ready), 1);

        // Reset in the middle of a LOAD_CMD pulse
        issue(OP_LOAD_CMD, 8'h10, k);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge osc);
            seen = dut_xtal;
        end
        chk("midrst_xtal_seen", int'(seen), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_xtal", int'(dut_xtal), 0);
        chk("midrst_data_oe", int'(dut_data_oe), 0);
        chk("midrst_data", int'(dut_data), 0);
        @(negedge osc); rst_n = 1'b1;
        @(negedge osc);
        chk("midrst_ready", int'(cmd_ready), 1);
        mon_en = 1'b1;

        // Load / PAGEL / READ vectors
        for (int i = 0; i < NV; i++) begin
            dut_q = v_q[i];
            issue(v_op[i], v_d[i], k);
            if (v_op[i] == OP_READ) begin
                push(3, k, 1, 6, 1'b0, 8'h00, v_xa[i], v_bs1[i], 1'b0, 1'b0);
                push(4, k, 7, 1, 1'b1, v_q[i], v_xa[i], v_bs1[i], 1'b0, 1'b0);
            end else begin
                push((v_op[i] == OP_PAGEL) ? 1 : 0, k, 3, 4, 1'b1, v_dd[i], v_xa[i], v_bs1[i],
                     1'b0, (v_op[i] != OP_PAGEL));
            end
            wait_idle(k, lat);
            chk($sformatf("vec%0d_ready_lat", i), lat, (v_op[i] == OP_READ) ? 8 : 9);
        end
        chk("read_rd_data", int'(rd_data), 8'hA5);

        // PROG with RDY low ~30 cycles, then high
        dut_rdy = 1'b0;
        issue(OP_PROG, 8'h02, k);
        push(2, k, 3, 4, 1'b0, 8'h00, 2'b01, 1'b0, 1'b1, 1'b0);
        repeat (30) @(posedge osc);
        #1 dut_rdy = 1'b1;
        m = cyc;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge osc);
            if (cmd_ready) begin lat = cyc - m; break; end
        end
        chk("prog_rdy_lat_2to3", int'(lat >= 2 && lat <= 3), 1);
        chk("prog_ok_timeout", int'(timeout), 0);

        // Second READ with BS1=1 BS2=1
        dut_q = 8'h3C;
        issue(OP_READ, 8'h03, k);
        push(3, k, 1, 6, 1'b0, 8'h00, 2'b01, 1'b1, 1'b1, 1'b0);
        push(4, k, 7, 1, 1'b1, 8'h3C, 2'b01, 1'b1, 1'b1, 1'b0);
        wait_idle(k, lat);
        chk("read2_ready_lat", lat, 8);

        // PROG with RDY stuck low -> timeout
        dut_rdy = 1'b0;
        issue(OP_PROG, 8'h00, k);
        push(2, k, 3, 4, 1'b0, 8'h00, 2'b01, 1'b0, 1'b0, 1'b0);
        wait_idle(k, lat);
        chk("to_ready_lat", lat, 1 + 2 + 4 + 2 + TO);
        chk("to_flag_set", int'(timeout), 1);
        dut_rdy = 1'b1;
        issue(OP_CLR, 8'h00, k);
        wait_idle(k, lat);
        chk("clr_ready_lat", lat, 2);
        chk("clr_timeout", int'(timeout), 0);

        // RDY arrives (after sync) in exactly the expiry cycle: success
        dut_rdy = 1'b0;
        issue(OP_PROG, 8'h00, k);
        push(2, k, 3, 4, 1'b0, 8'h00, 2'b01, 1'b0, 1'b0, 1'b0);
        repeat (TO + 5) @(posedge osc);
        #1 dut_rdy = 1'b1;
        wait_idle(k, lat);
        chk("edge_ready_lat", lat, 1 + 2 + 4 + 2 + TO);
        chk("edge_timeout", int'(timeout), 0);

        // cmd_valid while PAGEL busy is dropped
        issue(OP_PAGEL, 8'hEE, k);
        push(1, k, 3, 4, 1'b1, 8'h78, 2'b01, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge osc);
        #1 cmd_valid = 1'b1; cmd_op = OP_LOAD_CMD; cmd_data = 8'hFF;
        @(posedge osc);
        #1 cmd_valid = 1'b0;
        wait_idle(k, lat);
        chk("busy_pagel_lat", lat, 9);
        chk("busy_xa", int'({dut_xa1, dut_xa0}), 1);
        chk("busy_data", int'(dut_data), 8'h78);

        // Reserved op 12 while idle: ignored
        @(posedge osc);
        #1 cmd_valid = 1'b1; cmd_op = 4'd12; cmd_data = 8'h5A;
        @(posedge osc);
        #1 cmd_valid = 1'b0;
        @(negedge osc);
        chk("op12_ready", int'(cmd_ready), 1);
        repeat (12) @(posedge osc);
        #1;
        chk("op12_xa_bs", int'({dut_xa1, dut_xa0, dut_bs1, dut_bs2}), 4'b0100);
        chk("op12_data", int'(dut_data), 8'h78);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
